// File: rtl/seg7_pkg.sv
//==============================================================================
// Module   : seg7_pkg
// Brief    : Shared seven-segment pattern constants and digit decoder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package seg7_pkg;

    // Bit order is {A,B,C,D,E,F,G}, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    function automatic logic [6:0] segOf(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_prescaler.sv
//==============================================================================
// Module   : seg7_prescaler
// Brief    : Divide-by-DIV enable prescaler producing a single-cycle TICK.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg7_prescaler #(
    parameter int DIV   = 1000,
    parameter int DIV_W = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam logic [DIV_W-1:0] c_last = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_pc;

    assign TICK = EN && (r_pc == c_last);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc <= '0;
        end else if (CLR) begin
            r_pc <= '0;
        end else if (EN) begin
            r_pc <= TICK ? '0 : r_pc + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg7_digit_counter.sv
//==============================================================================
// Module   : seg7_digit_counter
// Brief    : Prescaled up/down decimal digit with registered segments, DP and
//            carry. Optional SEG7_PAUSE_BLINK_EN blinks the display while paused.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg7_digit_counter
    import seg7_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int DIV_W = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       UP,
    input  logic       LOAD,
    input  logic [3:0] LOAD_VAL,
    output logic [3:0] DIGIT,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       DP,
    output logic       CARRY
);

    logic       w_preEn;
    logic       w_tick;
    logic       w_step;
    logic       w_wrap;
    logic [3:0] w_nextDigit;
    logic [6:0] w_segOut;
    logic       w_dpOut;

    logic [3:0] r_digit;
    logic [6:0] r_seg;
    logic       r_dp;
    logic       r_carry;

`ifdef SEG7_PAUSE_BLINK_EN
    assign w_preEn = 1'b1;
`else
    assign w_preEn = EN;
`endif

    seg7_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (w_preEn),
        .CLR  (LOAD),
        .TICK (w_tick)
    );

    // LOAD wins over a coincident tick, so the tick is dropped entirely.
    assign w_step = w_tick && EN && !LOAD;
    assign w_wrap = w_step && (UP ? (r_digit == DIGIT_MAX) : (r_digit == 4'd0));

    always_comb begin
        w_nextDigit = r_digit;
        if (LOAD) begin
            w_nextDigit = (LOAD_VAL > DIGIT_MAX) ? DIGIT_MAX : LOAD_VAL;
        end else if (w_step) begin
            if (UP) begin
                w_nextDigit = w_wrap ? 4'd0 : r_digit + 4'd1;
            end else begin
                w_nextDigit = w_wrap ? DIGIT_MAX : r_digit - 4'd1;
            end
        end
    end

    // Segments decode the next digit so they land on the same edge as DIGIT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_digit <= 4'd0;
            r_seg   <= SEG_0;
            r_dp    <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_digit <= w_nextDigit;
            r_seg   <= segOf(w_nextDigit);
            r_carry <= w_wrap;
            if (w_wrap) begin
                r_dp <= ~r_dp;
            end
        end
    end

`ifdef SEG7_PAUSE_BLINK_EN
    logic r_blink;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_blink <= 1'b0;
        end else if (EN) begin
            r_blink <= 1'b0;
        end else if (w_tick) begin
            r_blink <= ~r_blink;
        end
    end

    assign w_segOut = r_blink ? SEG_BLANK : r_seg;
    assign w_dpOut  = r_dp & ~r_blink;
`else
    assign w_segOut = r_seg;
    assign w_dpOut  = r_dp;
`endif

    assign {A, B, C, D, E, F, G} = w_segOut;
    assign DIGIT = r_digit;
    assign DP    = w_dpOut;
    assign CARRY = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_seg7_digit_counter.sv
//==============================================================================
// Module   : tb_seg7_digit_counter
// Brief    : Directed self-checking bench for seg7_digit_counter (DIV=4 and DIV=1).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seg7_digit_counter;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       EN1;
    logic       UP;
    logic       LOAD;
    logic [3:0] LOAD_VAL;

    logic [3:0] digit4;
    logic [6:0] seg4;
    logic       dp4;
    logic       carry4;

    logic [3:0] digit1;
    logic [6:0] seg1;
    logic       dp1;
    logic       carry1;

    int passCnt  = 0;
    int totalCnt = 0;

    seg7_digit_counter #(.DIV(4), .DIV_W(16)) dut4 (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .DIGIT(digit4),
        .A(seg4[6]), .B(seg4[5]), .C(seg4[4]), .D(seg4[3]),
        .E(seg4[2]), .F(seg4[1]), .G(seg4[0]),
        .DP(dp4), .CARRY(carry4)
    );

    seg7_digit_counter #(.DIV(1), .DIV_W(1)) dut1 (
        .CLK(CLK), .RST(RST), .EN(EN1), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .DIGIT(digit1),
        .A(seg1[6]), .B(seg1[5]), .C(seg1[4]), .D(seg1[3]),
        .E(seg1[2]), .F(seg1[1]), .G(seg1[0]),
        .DP(dp1), .CARRY(carry1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0; EN = 1'b0; EN1 = 1'b0; UP = 1'b1; LOAD = 1'b0; LOAD_VAL = 4'd0;
        #12;
        chk("rst_digit", 8'(digit4), 8'd0);
        chk("rst_seg",   8'(seg4),   8'h7E);
        chk("rst_dp",    8'(dp4),    8'd0);
        chk("rst_carry", 8'(carry4), 8'd0);

        // Count up from reset: first change on the 4th enabled edge.
        edges(1);
        RST = 1'b1; EN = 1'b1; UP = 1'b1;
        edges(3);
        chk("up_e3_digit", 8'(digit4), 8'd0);
        edges(1);
        chk("up_e4_digit", 8'(digit4), 8'd1);
        chk("up_e4_seg",   8'(seg4),   8'h30);
        edges(4);
        chk("up_e8_digit", 8'(digit4), 8'd2);
        chk("up_e8_seg",   8'(seg4),   8'h6D);

        // Load 8, count up through the 9->0 wrap.
        LOAD = 1'b1; LOAD_VAL = 4'd8;
        edges(1);
        LOAD = 1'b0;
        chk("load8_digit", 8'(digit4), 8'd8);
        edges(4);
        chk("to9_digit", 8'(digit4), 8'd9);
        chk("to9_carry", 8'(carry4), 8'd0);
        edges(4);
        chk("wrap_digit", 8'(digit4), 8'd0);
        chk("wrap_seg",   8'(seg4),   8'h7E);
        chk("wrap_carry", 8'(carry4), 8'd1);
        chk("wrap_dp",    8'(dp4),    8'd1);
        edges(1);
        chk("wrap_carry_off", 8'(carry4), 8'd0);

        // Down-count from 0 wraps to 9 and returns DP to 0.
        UP = 1'b0;
        edges(2);
        chk("down_pre_digit", 8'(digit4), 8'd0);
        edges(1);
        chk("down_digit", 8'(digit4), 8'd9);
        chk("down_seg",   8'(seg4),   8'h7B);
        chk("down_carry", 8'(carry4), 8'd1);
        chk("down_dp",    8'(dp4),    8'd0);

        // LOAD 13 coincident with a would-be wrapping tick.
        UP = 1'b1;
        edges(3);
        LOAD = 1'b1; LOAD_VAL = 4'd13;
        edges(1);
        LOAD = 1'b0;
        chk("ld13_digit", 8'(digit4), 8'd9);
        chk("ld13_carry", 8'(carry4), 8'd0);
        chk("ld13_dp",    8'(dp4),    8'd0);
        edges(3);
        chk("ld13_e3_digit", 8'(digit4), 8'd9);
        edges(1);
        chk("ld13_e4_digit", 8'(digit4), 8'd0);
        chk("ld13_e4_dp",    8'(dp4),    8'd1);

        // Pause after two enabled clocks; phase must be retained.
        edges(2);
        EN = 1'b0;
        edges(10);
        chk("pause_digit", 8'(digit4), 8'd0);
        EN = 1'b1;
        edges(1);
        chk("resume_e1_digit", 8'(digit4), 8'd0);
        edges(1);
        chk("resume_e2_digit", 8'(digit4), 8'd1);

        // Asynchronous reset mid-period with DIGIT=7, DP=1.
        LOAD = 1'b1; LOAD_VAL = 4'd7;
        edges(1);
        LOAD = 1'b0;
        chk("pre_rst_digit", 8'(digit4), 8'd7);
        chk("pre_rst_dp",    8'(dp4),    8'd1);
        edges(2);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_digit", 8'(digit4), 8'd0);
        chk("arst_seg",   8'(seg4),   8'h7E);
        chk("arst_dp",    8'(dp4),    8'd0);
        chk("arst_carry", 8'(carry4), 8'd0);

        // DIV=1 instance: tick on every enabled cycle.
        edges(1);
        RST = 1'b1; EN = 1'b0; EN1 = 1'b1; UP = 1'b1;
        edges(1);
        chk("div1_e1_digit", 8'(digit1), 8'd1);
        edges(1);
        chk("div1_e2_digit", 8'(digit1), 8'd2);
        chk("div1_e2_seg",   8'(seg1),   8'h6D);
        edges(1);
        chk("div1_e3_digit", 8'(digit1), 8'd3);
        chk("div4_frozen",   8'(digit4), 8'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_digit_counter.md
Name: seg7_digit_counter

Overview:
- Upstream feeder stage for the seven-segment display path.
- Divides CLK down to a count tick and keeps a decimal digit 0-9 that counts up or down.
- Outputs the registered segment pattern A..G, a DP that toggles on every wrap, and a one-cycle CARRY pulse so display stages can be cascaded.
- Sits between the board clock/reset and the segment pins, in place of the fixed-pattern sequencer.

Parameters:
- DIV, default 1000: prescaler ratio; one count tick every DIV enabled clocks. Legal range 1..65535.
- DIV_W, default 16: prescaler counter width; must satisfy 2**DIV_W >= DIV.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to CLK.
- EN  input  1  count enable; 1 = prescaler runs and ticks advance the digit.
- UP  input  1  direction; 1 = increment, 0 = decrement; sampled only on the tick cycle.
- LOAD  input  1  synchronous load strobe.
- LOAD_VAL  input  4  value loaded when LOAD=1.
- DIGIT  output  4  current digit, 0..9.
- A, B, C, D, E, F, G  output  1 each  registered segments, active-high, standard lettering (A top, G middle).
- DP  output  1  decimal point; toggles on each wrap.
- CARRY  output  1  one-cycle pulse on wrap (9->0 up, 0->9 down).

Behaviour:
- Reset (RST=0): prescaler=0, DIGIT=0, segments = pattern for 0 (A..F=1, G=0), DP=0, CARRY=0.
- Prescaler:
  - pc increments each clock while EN=1.
  - When pc==DIV-1 and EN=1: pc->0 and tick=1 in that cycle.
  - EN=0 freezes pc; no tick.
  - DIV=1: tick on every enabled cycle.
- Digit update, priority LOAD > tick:
  - LOAD=1: DIGIT <= min(LOAD_VAL, 9), i.e. 10..15 load 9; pc <= 0. No CARRY, DP unchanged, and any coincident tick is discarded.
  - Tick with UP=1: 9 -> 0 with wrap, otherwise +1.
  - Tick with UP=0: 0 -> 9 with wrap, otherwise -1.
  - On wrap: CARRY=1 for exactly the following cycle (same edge DIGIT takes its wrapped value), and DP <= ~DP on that same edge.
- Segments:
  - A..G are registered and updated on the same edge as DIGIT, so they always match DIGIT; zero added latency.
  - Encoding, lit segments per digit: 0=ABCDEF, 1=BC, 2=ABDEG, 3=ABCDG, 4=BCFG, 5=ACDFG, 6=ACDEFG, 7=ABC, 8=ABCDEFG, 9=ABCDFG.
  - DIGIT never holds 10..15.
- Boundaries:
  - UP may change at any time and only matters on tick cycles.
  - EN falling mid-period keeps pc; counting resumes from the same phase.
  - RST asserted mid-period discards pc, digit, DP and a pending CARRY immediately.

Optional Feature:
- Macro: SEG7_PAUSE_BLINK_EN.
- Defined:
  - The prescaler runs regardless of EN; EN gates only the digit update.
  - A blink flag toggles on each prescaler wrap while EN=0, and clears when EN=1 or on reset.
  - While blink=1, A..G and DP drive 0; DIGIT and the internal DP state are unaffected.
  - LOAD still resets pc.
- Undefined: behaviour exactly as above; no blink register; prescaler frozen while EN=0.

Decomposition:
- Shared package seg7_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK (7-bit, order {A,B,C,D,E,F,G});
  - DIGIT_MAX=9.
- Display stages reuse the same constants.
- One sub-module, seg7_prescaler (parameters DIV, DIV_W; ports CLK, RST, EN, CLR; output TICK), instanced once.
- Digit/segment/DP logic stays in the top.

Test Plan (DIV=4 unless stated):
- Reset then EN=1, UP=1: DIGIT steps 0->1->2 every 4 clocks; first change on the 4th enabled edge; segments for 1 = B,C only.
- Count up from LOAD_VAL=8: after 2 ticks DIGIT=0, CARRY high exactly 1 cycle on that edge, DP 0->1; next wrap sets DP back to 0.
- UP=0 from DIGIT=0: one tick gives DIGIT=9, segments ABCDFG, CARRY pulse, DP toggles.
- LOAD with LOAD_VAL=13 coincident with a tick: DIGIT=9, no CARRY, pc restarts so the next tick comes 4 clocks later.
- EN low for 10 clocks after 2 enabled clocks: DIGIT frozen; after EN=1 the tick arrives 2 clocks later. With SEG7_PAUSE_BLINK_EN, A..G/DP go blank and lit alternately every 4 clocks while EN=0.
- RST pulsed low mid-period (DIGIT=7, DP=1): outputs go to 0-pattern, DP=0 and CARRY=0 without waiting for a clock edge; DIV=1 run then ticks every cycle.
